// File: rtl/axil_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_reg_pkg
//  Description : Shared types and constants for the AXI4-Lite register slave.
//                Response codes, the register word type and the encodings of
//                the independent write and read state machines.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [31:0] reg_word_t;

    // Write FSM: collect AW and W (any order), then hold the B response.
    typedef enum logic [0:0] {
        W_CAPT = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    // Read FSM: accept AR, then hold the R response.
    typedef enum logic [0:0] {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage : axil_reg_pkg
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_if
//  Description : AXI4-Lite bundle, 32-bit address and data, 4-bit write
//                strobe. Modport s is the slave (responder) view, modport m
//                the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lite_if;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport s (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport m (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface : axi4_lite_if
`default_nettype wire

// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axil_reg_slave
//  Description : AXI4-Lite responder backed by a bank of N_REGS 32-bit
//                registers. Each register is read-write control or, when its
//                RO_MASK bit is set, a read-only window onto status_i.
//                Write and read paths are independent state machines.
//  Ports       : aclk      - bus clock
//                areset    - asynchronous active-high reset
//                axi       - AXI4-Lite slave modport
//                ctrl_o    - current value of every RW register
//                status_i  - read-only values, sampled on the AR handshake
//                wr_stb_o  - one-cycle pulse the cycle after register i is
//                            written
//                rd_stb_o  - one-cycle pulse the cycle after the AR handshake
//                            on register i
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter int               N_REGS   = 16,
    parameter int               LOCAL_AW = 12,
    parameter logic [N_REGS-1:0] RO_MASK = '0
) (
    input  logic                     aclk,
    input  logic                     areset,
    axi4_lite_if.s                   axi,
    output logic [N_REGS-1:0][31:0]  ctrl_o,
    input  logic [N_REGS-1:0][31:0]  status_i,
    output logic [N_REGS-1:0]        wr_stb_o,
    output logic [N_REGS-1:0]        rd_stb_o
);

    localparam int          IDX_W      = $clog2(N_REGS);
    localparam logic [31:0] LOCAL_MASK = (LOCAL_AW >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'd1 << LOCAL_AW) - 32'd1);

    // Any set bit between the register index field and LOCAL_AW means the
    // access lands outside the bank; bits above LOCAL_AW are don't-care.
    function automatic logic addr_oor(input logic [31:0] a);
        return ((a & LOCAL_MASK) >> (2 + IDX_W)) != 32'd0;
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return a[2 +: IDX_W];
    endfunction

    // Protection bits carry no meaning for this register bank.
    logic prot_unused;
    assign prot_unused = ^{axi.awprot, axi.arprot};

    // ------------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------------
    w_state_t                  w_state_q,  w_state_d;
    logic                      aw_done_q,  aw_done_d;
    logic                      w_done_q,   w_done_d;
    logic [31:0]               awaddr_q,   awaddr_d;
    reg_word_t                 wdata_q,    wdata_d;
    logic [3:0]                wstrb_q,    wstrb_d;
    logic                      bvalid_q,   bvalid_d;
    logic [1:0]                bresp_q,    bresp_d;
    logic [N_REGS-1:0]         wr_stb_q,   wr_stb_d;
    logic [N_REGS-1:0][31:0]   ctrl_q,     ctrl_d;

    r_state_t                  r_state_q,  r_state_d;
    logic                      rvalid_q,   rvalid_d;
    reg_word_t                 rdata_q,    rdata_d;
    logic [1:0]                rresp_q,    rresp_d;
    logic [N_REGS-1:0]         rd_stb_q,   rd_stb_d;

    // Readies depend only on registered state, never on a valid.
    logic awready_w, wready_w, arready_w;
    assign awready_w = (w_state_q == W_CAPT) && !aw_done_q;
    assign wready_w  = (w_state_q == W_CAPT) && !w_done_q;
    assign arready_w = (r_state_q == R_ADDR);

    // ------------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_stb_d  = '0;
        ctrl_d    = ctrl_q;

        case (w_state_q)
            W_CAPT: begin
                if (axi.awvalid && awready_w) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = axi.awaddr;
                end
                if (axi.wvalid && wready_w) begin
                    w_done_d = 1'b1;
                    wdata_d  = axi.wdata;
                    wstrb_d  = axi.wstrb;
                end
                // Commit on the same edge that completes the second channel,
                // using the just-captured values where applicable.
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    if (addr_oor(awaddr_d) || RO_MASK[idx_of(awaddr_d)]) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        bresp_d                     = RESP_OKAY;
                        wr_stb_d[idx_of(awaddr_d)]  = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_d[b]) begin
                                ctrl_d[idx_of(awaddr_d)][8*b +: 8] = wdata_d[8*b +: 8];
                            end
                        end
                    end
                end
            end
            W_RESP: begin
                if (axi.bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_CAPT;
                end
            end
            default: w_state_d = W_CAPT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read path (sees ctrl_q, so a colliding write is not yet visible)
    // ------------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_stb_d  = '0;

        case (r_state_q)
            R_ADDR: begin
                if (axi.arvalid) begin
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                    if (addr_oor(axi.araddr)) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rresp_d                    = RESP_OKAY;
                        rd_stb_d[idx_of(axi.araddr)] = 1'b1;
                        rdata_d = RO_MASK[idx_of(axi.araddr)] ? status_i[idx_of(axi.araddr)]
                                                              : ctrl_q[idx_of(axi.araddr)];
                    end
                end
            end
            R_DATA: begin
                if (axi.rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_ADDR;
                end
            end
            default: r_state_d = R_ADDR;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_CAPT;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            wr_stb_q  <= '0;
            ctrl_q    <= '0;
            r_state_q <= R_ADDR;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rd_stb_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wr_stb_q  <= wr_stb_d;
            ctrl_q    <= ctrl_d;
            r_state_q <= r_state_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rd_stb_q  <= rd_stb_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign axi.awready = awready_w;
    assign axi.wready  = wready_w;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_w;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    assign ctrl_o   = ctrl_q;
    assign wr_stb_o = wr_stb_q;
    assign rd_stb_o = rd_stb_q;

endmodule : axil_reg_slave
`default_nettype wire

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder terminating the host-side AXI4-Lite master path coming from the PCIe bridge.
- Implements a bank of N_REGS 32-bit registers. Each register is either read-write control or read-only status.
- Exposes control values and per-register write/read strobes to fabric logic.
- Sits on the PCIe clock domain, directly behind the AXI4 to AXI4-Lite protocol converter.

Parameters:
- N_REGS, 16, number of 32-bit registers (power of two, 2..256).
- LOCAL_AW, 12, number of low address bits decoded; upper address bits are ignored.
- RO_MASK, 16'h0000, bit i = 1 makes register i read-only; reads return status_i[i].

Ports:
- aclk  in  1  bus clock.
- areset  in  1  asynchronous, active-high reset.
- axi  axi4_lite_if.s  -  AXI4-Lite slave modport (32-bit addr/data, 4-bit wstrb).
- ctrl_o  out  N_REGS x 32  current value of each RW register.
- status_i  in  N_REGS x 32  read-only values, sampled at AR handshake.
- wr_stb_o  out  N_REGS  1-cycle pulse, asserted the cycle after register i is written.
- rd_stb_o  out  N_REGS  1-cycle pulse, asserted the cycle after the AR handshake on register i.

Behaviour:
- Reset values:
  - awready = wready = arready = 1.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.
  - ctrl_o = 0; all strobes = 0.
  - Reset asserted mid-transaction drops every valid immediately and discards pending captures.
- Address decode:
  - idx = addr[2 +: log2(N_REGS)]; addr[1:0] is ignored.
  - Out of range when addr[LOCAL_AW-1 : 2+log2(N_REGS)] != 0.
  - awprot and arprot are ignored.
- Write path, states W_CAPT and W_RESP:
  - W_CAPT: AW and W are accepted independently, in either order or in the same cycle.
  - Once a channel's handshake completes, its ready deasserts and its addr or data+strb is latched.
  - When both channels are latched, the write commits on that same clock edge, bvalid asserts the next cycle, and the FSM moves to W_RESP.
  - Commit updates only the bytes whose wstrb bit is set.
  - wstrb = 0: no update; response is OKAY; the wr_stb_o pulse is still issued.
  - Out-of-range address: no update; bresp = SLVERR (2'b10); no strobe.
  - Write to an RO register: no update; bresp = SLVERR; no strobe.
  - W_RESP: hold bvalid and bresp until bready. Then return to W_CAPT with awready = wready = 1 on the following cycle.
  - At most one write outstanding at a time.
- Read path, states R_ADDR and R_DATA:
  - R_ADDR: arready = 1. On the AR handshake, latch rdata and rresp and go to R_DATA; rvalid = 1 the next cycle (latency 1).
  - rdata source: ctrl_o[idx] for RW registers, status_i[idx] for RO registers.
  - Out-of-range address: rdata = 0, rresp = SLVERR.
  - R_DATA: arready = 0. Hold rvalid, rdata and rresp stable until rready, then return to R_ADDR.
- Read and write paths are fully independent.
  - A read handshake in the same cycle as a write commit to the same register returns the pre-write value.
- Back-to-back transactions:
  - Minimum spacing is 2 cycles per write (capture, then response).
  - Minimum spacing is 2 cycles per read.
- Protocol rules:
  - No combinational path from any valid to any ready.
  - bvalid and rvalid never drop without the matching ready.

Decomposition:
- Package axil_reg_pkg holds:
  - constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - typedef reg_word_t = logic [31:0];
  - enum w_state_t {W_CAPT, W_RESP};
  - enum r_state_t {R_ADDR, R_DATA}.
- No sub-module: read FSM, write FSM and the register array stay in one module.

Test Plan:
- Write and read back: AW and W in the same cycle, addr 0x004, data 0xDEADBEEF, wstrb 4'hF.
  - Expect bresp OKAY one cycle after the handshakes and wr_stb_o[1] pulse.
  - Read of 0x004 returns 0xDEADBEEF with rresp OKAY, rvalid one cycle after AR, and rd_stb_o[1] pulse.
- Split channels plus byte strobes: W is presented 3 cycles before AW (addr 0x008, data 0x11223344, wstrb 4'b0101) onto a register holding 0xFFFFFFFF.
  - Expect ctrl_o[2] = 0xFF22FF44, with a single bvalid issued only after AW arrives.
- Errors, with RO_MASK bit 3 set:
  - Write 0x00C: SLVERR and register unchanged.
  - Read 0x00C with status_i[3] = 0xA5A5A5A5: rdata 0xA5A5A5A5, OKAY.
  - Read 0x040: SLVERR, rdata 0.
  - Write 0x080: SLVERR, no strobes.
- Backpressure: hold bready and rready low for 5 cycles.
  - Expect bvalid, rvalid, bresp, rresp and rdata stable throughout.
  - Expect awready = wready = arready = 0 until the response handshake.
- Collision and reset: read 0x000 and complete a write of 0x12345678 to 0x000 in the same cycle.
  - Expect the read to return the old value and a subsequent read to return 0x12345678.
  - Then assert areset while bvalid = 1: expect bvalid = 0 and ctrl_o = 0 immediately, and readies = 1 once reset is released.
